fmul_rr_scheduler: RTL and testbench

//  Shares one pipelined IEEE754 multiplier (fixed latency MULT_LAT) among N_REQ requesters.

---
 rtl/fmul_rr_scheduler.sv | 169 ++++++++++++++++
 tb/tb_fmul_rr_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_rr_scheduler.sv
// fmul_rr_scheduler
//   Shares one pipelined floating-point multiplier (fixed latency MULT_LAT)
//   among N_REQ requesters. At most one request is issued per cycle, picked
//   round-robin. A {valid,id} tag follows each operation down a shift
//   register that matches the multiplier latency. Every returning result is
//   pushed into a response FIFO. Issue is credit-limited, so the FIFO cannot
//   overflow.
//
// Ports
//   clk        : clock, all state updates on posedge
//   reset      : synchronous reset, active low
//   req_valid  : request pending, bit i belongs to requester i
//   req_ready  : one-hot grant (or zero); a transfer is valid & ready
//   req_op_a   : operand A of requester i at [i*WIDTH +: WIDTH]
//   req_op_b   : operand B, packed the same way
//   req_opcode : opcode of requester i at [i*2 +: 2]
//   mul_op_a   : operand A to the multiplier (zero when nothing is issued)
//   mul_op_b   : operand B to the multiplier (zero when nothing is issued)
//   mul_opcode : opcode to the multiplier (zero when nothing is issued)
//   mul_res    : multiplier result, MULT_LAT cycles after its operands
//   rsp_valid  : response FIFO is not empty
//   rsp_ready  : consumer takes the FIFO head
//   rsp_id     : requester id of the FIFO head
//   rsp_data   : product at the FIFO head
module fmul_rr_scheduler #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 64,
  parameter int MULT_LAT  = 1,
  parameter int RSP_DEPTH = 4,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_op_a,
  input  logic [N_REQ*WIDTH-1:0]   req_op_b,
  input  logic [N_REQ*2-1:0]       req_opcode,
  output logic [WIDTH-1:0]         mul_op_a,
  output logic [WIDTH-1:0]         mul_op_b,
  output logic [1:0]               mul_opcode,
  input  logic [WIDTH-1:0]         mul_res,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [ID_W-1:0]       rr_ptr;
  logic [MULT_LAT-1:0]   tag_valid;
  logic [ID_W-1:0]       tag_id [MULT_LAT];
  logic [ID_W+WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;

  int                    inflight;
  logic                  can_issue;
  logic                  gnt_found;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       scan_idx;
  int                    scan_sum;
  logic                  gnt_valid;
  logic                  push;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every valid tag stage holds a result that will land in the FIFO, so it
  // already owns a FIFO slot. Pre-edge occupancy only: a pop in this same
  // cycle does not free a credit until the next cycle.
  always_comb begin
    inflight = 0;
    for (int s = 0; s < MULT_LAT; s++) begin
      inflight = inflight + int'(tag_valid[s]);
    end
  end

  assign can_issue = reset && ((inflight + int'(fifo_cnt)) < RSP_DEPTH);

  // Round-robin scan that starts at rr_ptr; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    scan_sum  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = int'(rr_ptr) + k;
      if (scan_sum >= N_REQ) begin
        scan_sum = scan_sum - N_REQ;
      end
      scan_idx = ID_W'(scan_sum);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_idx;
      end
    end
  end

  assign gnt_valid = can_issue && gnt_found;

  always_comb begin
    req_ready  = '0;
    mul_op_a   = '0;
    mul_op_b   = '0;
    mul_opcode = '0;
    if (gnt_valid) begin
      req_ready  = N_REQ'(1) << gnt_id;
      mul_op_a   = req_op_a[gnt_id*WIDTH +: WIDTH];
      mul_op_b   = req_op_b[gnt_id*WIDTH +: WIDTH];
      mul_opcode = req_opcode[gnt_id*2 +: 2];
    end
  end

  assign push      = tag_valid[MULT_LAT-1];
  assign rsp_valid = reset && (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_id    = fifo_mem[rd_ptr][ID_W+WIDTH-1:WIDTH];
  assign rsp_data  = fifo_mem[rd_ptr][WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr    <= '0;
      tag_valid <= '0;
      for (int s = 0; s < MULT_LAT; s++) begin
        tag_id[s] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
    end else begin
      if (gnt_valid) begin
        rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      // The multiplier never stalls, so the tag line shifts every cycle.
      tag_valid[0] <= gnt_valid;
      tag_id[0]    <= gnt_valid ? gnt_id : '0;
      for (int s = 1; s < MULT_LAT; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end
      // The credit scheme makes a push into a full FIFO impossible.
      assert (!(push && (fifo_cnt == CNT_W'(RSP_DEPTH))));
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      fifo_mem[wr_ptr] <= {tag_id[MULT_LAT-1], mul_res};
    end
  end

endmodule

// File: tb/tb_fmul_rr_scheduler.sv
module tb_fmul_rr_scheduler;
  localparam int N     = 4;
  localparam int W     = 64;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_op_a;
  logic [N*W-1:0]   req_op_b;
  logic [N*2-1:0]   req_opcode;
  logic [W-1:0]     mul_op_a;
  logic [W-1:0]     mul_op_b;
  logic [1:0]       mul_opcode;
  logic [W-1:0]     mul_res;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_data;

  fmul_rr_scheduler #(.N_REQ(N), .WIDTH(W), .MULT_LAT(LAT), .RSP_DEPTH(DEPTH), .ID_W(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_opcode(req_opcode),
    .mul_op_a(mul_op_a), .mul_op_b(mul_op_b), .mul_opcode(mul_opcode),
    .mul_res(mul_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data));

  always #5 clk = ~clk;

  // Multiplier stand-in: real product, opcode folded into the low bits so
  // that opcode routing is visible in the response data.
  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    return $realtobits($bitstoreal(a) * $bitstoreal(b)) ^ {62'd0, op};
  endfunction

  logic [W-1:0] mres [LAT];
  always @(posedge clk) begin
    mres[0] <= fmul(mul_op_a, mul_op_b, mul_opcode);
    for (int s = 1; s < LAT; s++) mres[s] <= mres[s-1];
  end
  assign mul_res = mres[LAT-1];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  logic [W-1:0] cur_a [N];
  logic [W-1:0] cur_b [N];
  logic [1:0]   cur_op [N];
  logic [N-1:0] oneshot;

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_op_a[i*W +: W]   = cur_a[i];
      req_op_b[i*W +: W]   = cur_b[i];
      req_opcode[i*2 +: 2] = cur_op[i];
    end
  endtask

  function automatic logic [63:0] rdbl();
    return {1'($urandom_range(0, 1)), 11'($urandom_range(973, 1073)), 20'($urandom), 32'($urandom)};
  endfunction

  task automatic new_op(input int i);
    cur_a[i]  = rdbl();
    cur_b[i]  = rdbl();
    cur_op[i] = 2'($urandom_range(0, 3));
    pack();
  endtask

  // Reference model: queues of in-flight and buffered responses.
  typedef struct {
    int          id;
    logic [63:0] d;
    int          t;
  } ent_t;

  ent_t pipe[$];
  ent_t fifo[$];
  int   rr = 0;
  int   cyc = 0;
  int   last_gnt = -1;
  int   gnt_log[$];
  int   rsp_log[$];
  int   max_fill = 0;

  always @(negedge clk) begin : model
    int g;
    int i;
    bit found;
    bit ev;
    logic [N-1:0] er;
    ent_t e;
    found = 1'b0;
    g = 0;
    if (reset && (pipe.size() + fifo.size() < DEPTH)) begin
      for (int k = 0; k < N; k++) begin
        i = (rr + k) % N;
        if (!found && req_valid[i]) begin
          found = 1'b1;
          g = i;
        end
      end
    end
    er = '0;
    if (found) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("mul_op_a", mul_op_a, found ? cur_a[g] : 64'd0);
    chk("mul_op_b", mul_op_b, found ? cur_b[g] : 64'd0);
    chk("mul_opcode", mul_opcode, found ? cur_op[g] : 2'd0);
    ev = reset && (fifo.size() > 0);
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("rsp_id", rsp_id, fifo[0].id);
      chk("rsp_data", rsp_data, fifo[0].d);
    end
    if (!reset) begin
      rr = 0;
      pipe.delete();
      fifo.delete();
    end else begin
      if (ev && rsp_ready) begin
        rsp_log.push_back(int'(rsp_id));
        void'(fifo.pop_front());
      end
      if (pipe.size() > 0 && pipe[0].t + LAT == cyc) begin
        fifo.push_back(pipe[0]);
        void'(pipe.pop_front());
      end
      if (found) begin
        e.id = g;
        e.d  = fmul(cur_a[g], cur_b[g], cur_op[g]);
        e.t  = cyc;
        pipe.push_back(e);
        rr = (g + 1) % N;
        gnt_log.push_back(g);
      end
    end
    if (fifo.size() > max_fill) max_fill = fifo.size();
    last_gnt = found ? g : -1;
    cyc++;
  end

  int grants_phase = 0;

  task automatic tick();
    int g;
    @(posedge clk);
    #1;
    if (last_gnt >= 0) begin
      g = last_gnt;
      new_op(g);
      if (oneshot[g]) req_valid[g] = 1'b0;
      grants_phase++;
    end
  endtask

  initial begin
    reset = 1'b0;
    rsp_ready = 1'b1;
    oneshot = '1;
    req_valid = '1;
    for (int i = 0; i < N; i++) new_op(i);
    repeat (3) tick();
    #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 1'b0);

    // single op: 1.0 * 2.0 from requester 0
    reset = 1'b1;
    req_valid = 4'b0001;
    cur_a[0] = 64'h3FF0000000000000;
    cur_b[0] = 64'h4000000000000000;
    cur_op[0] = 2'd0;
    pack();
    #1;
    chk("t1_grant", req_ready, 4'b0001);
    tick();
    #1;
    chk("t1_valid_t1", rsp_valid, 1'b0);
    tick();
    #1;
    chk("t1_valid_t2", rsp_valid, 1'b1);
    chk("t1_id", rsp_id, 2'd0);
    chk("t1_data", rsp_data, 64'h4000000000000000);
    tick();

    // all requesters continuously valid, starting from a fresh rr pointer
    reset = 1'b0;
    tick();
    reset = 1'b1;
    oneshot = '0;
    gnt_log.delete();
    rsp_log.delete();
    req_valid = '1;
    repeat (12) tick();
    req_valid = '0;
    repeat (4) tick();
    chk("t2_gnt_count", gnt_log.size(), 12);
    chk("t2_rsp_count", rsp_log.size(), 12);
    for (int k = 0; k < 8 && k < gnt_log.size(); k++) chk("t2_gnt_order", gnt_log[k], k % 4);
    for (int k = 0; k < 8 && k < rsp_log.size(); k++) chk("t2_rsp_order", rsp_log[k], k % 4);

    // credit limit with a stalled consumer
    rsp_ready = 1'b0;
    grants_phase = 0;
    req_valid = 4'b0010;
    repeat (8) tick();
    #1;
    chk("t3_accepted", grants_phase, 4);
    chk("t3_blocked", req_ready, 4'b0000);
    rsp_ready = 1'b1;
    repeat (6) tick();
    chk("t3_regrant", grants_phase, 9);
    req_valid = '0;
    repeat (6) tick();

    // round-robin pointer behaviour
    oneshot = '1;
    gnt_log.delete();
    req_valid = 4'b0100;
    tick();
    tick();
    req_valid = 4'b0100;
    #1;
    chk("t4_same_cycle", req_ready, 4'b0100);
    tick();
    tick();
    req_valid = 4'b1010;
    tick();
    tick();
    tick();
    chk("t4_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      chk("t4_g0", gnt_log[0], 2);
      chk("t4_g1", gnt_log[1], 2);
      chk("t4_g2", gnt_log[2], 3);
      chk("t4_g3", gnt_log[3], 1);
    end
    repeat (3) tick();

    // reset while an op is in flight
    req_valid = 4'b0001;
    tick();
    reset = 1'b0;
    tick();
    #1;
    chk("t5_in_reset", rsp_valid, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("t5_after_reset", rsp_valid, 1'b0);
    tick();
    #1;
    chk("t5_late_res", rsp_valid, 1'b0);
    cur_a[3] = 64'h4000000000000000;
    cur_b[3] = 64'h4008000000000000;
    cur_op[3] = 2'd0;
    pack();
    req_valid = 4'b1000;
    #1;
    chk("t5_grant", req_ready, 4'b1000);
    tick();
    tick();
    #1;
    chk("t5_valid", rsp_valid, 1'b1);
    chk("t5_id", rsp_id, 2'd3);
    chk("t5_data", rsp_data, 64'h4018000000000000);
    tick();

    // FIFO wrap with the consumer toggling
    gnt_log.delete();
    rsp_log.delete();
    grants_phase = 0;
    max_fill = 0;
    oneshot = '0;
    for (int c = 0; c < 60; c++) begin
      rsp_ready = ~rsp_ready;
      req_valid = (grants_phase < 10) ? N'($urandom_range(1, 15)) : '0;
      tick();
    end
    rsp_ready = 1'b1;
    chk("t6_grants", grants_phase, 10);
    chk("t6_rsps", rsp_log.size(), 10);
    for (int k = 0; k < 10 && k < rsp_log.size() && k < gnt_log.size(); k++)
      chk("t6_order", rsp_log[k], gnt_log[k]);
    chk("t6_fill_bound", max_fill <= DEPTH, 1'b1);

    // random traffic with occasional resets
    oneshot = '1;
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
      reset = ($urandom_range(0, 99) != 0);
      tick();
    end
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
